int_seq_ctrl: RTL

Parametrised interrupt/exception sequencer for the LC3 pipeline. It arbitrates NCH prioritised interrupt lines plus one synchronous exception. On entry it pushes PSR and PC onto the supervisor stack, fetches the handler address from the vector table and redirects the PC. It also executes the RTI return sequence. All memory traffic uses a ready-handshaked port, so the block tolerates wait states.

---
 rtl/int_seq_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/int_seq_ctrl.sv
// int_seq_ctrl: interrupt/exception sequencer for the LC3 pipeline.
// Arbitrates NCH prioritised level interrupts plus one synchronous exception.
// On entry it pushes PSR and PC onto the supervisor stack, fetches the handler
// address from the vector table and redirects the PC. It also runs the RTI pop
// sequence. All memory traffic waits on mem_ready.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   irq, irq_pri         level requests and per-channel priorities
//   exc_req, exc_vec     exception request and its vector number
//   rti_req              return-from-interrupt request
//   cur_pc/cur_psr/ssp   processor state sampled at acceptance
//   mem_*                ready-handshaked memory port
//   busy                 pipeline stall while a sequence runs
//   new_pc/new_psr/sp_out with pc_load/psr_load/sp_load: register updates
//   irq_ack              one-hot ack of the accepted channel
//   done                 end-of-sequence pulse
module int_seq_ctrl #(
  parameter int unsigned     DW       = 16,
  parameter int unsigned     NCH      = 4,
  parameter int unsigned     PRI_W    = 3,
  parameter int unsigned     PRI_LSB  = 8,
  parameter logic [DW-1:0]   VEC_BASE = 16'h0100,
  parameter logic [7:0]      IRQ_VEC0 = 8'h80
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH-1:0]     irq,
  input  logic [NCH*PRI_W-1:0] irq_pri,
  input  logic               exc_req,
  input  logic [7:0]         exc_vec,
  input  logic               rti_req,
  input  logic [DW-1:0]      cur_pc,
  input  logic [DW-1:0]      cur_psr,
  input  logic [DW-1:0]      ssp,
  output logic [DW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic               mem_rd,
  output logic               mem_we,
  input  logic [DW-1:0]      mem_rdata,
  input  logic               mem_ready,
  output logic               busy,
  output logic [DW-1:0]      new_pc,
  output logic               pc_load,
  output logic [DW-1:0]      new_psr,
  output logic               psr_load,
  output logic [DW-1:0]      sp_out,
  output logic               sp_load,
  output logic [NCH-1:0]     irq_ack,
  output logic               done
);

  typedef enum logic [2:0] {
    StIdle, StPushPsr, StPushPc, StFetch, StLoad, StPopPc, StPopPsr, StRLoad
  } stateT;

  stateT state, stateNext;

  logic             irqHit;
  logic [2:0]       irqSel;
  logic [PRI_W-1:0] bestPri, chPri, curPri;

  logic             isIrqQ;
  logic [2:0]       chanQ;
  logic [PRI_W-1:0] priQ;
  logic [7:0]       vecQ;
  logic [DW-1:0]    pcQ, psrQ, sspQ, dataQ;
  logic [DW-1:0]    newPcQ, newPsrQ, spOutQ;
  logic [DW-1:0]    entryPsr;

  assign curPri = cur_psr[PRI_LSB +: PRI_W];

  // Strictly-greater compare keeps the lowest index on priority ties.
  always_comb begin
    irqHit  = 1'b0;
    irqSel  = '0;
    bestPri = '0;
    chPri   = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      chPri = irq_pri[i*PRI_W +: PRI_W];
      if (irq[i] && (chPri > curPri) && (!irqHit || (chPri > bestPri))) begin
        irqHit  = 1'b1;
        irqSel  = 3'(i);
        bestPri = chPri;
      end
    end
  end

  always_comb begin
    entryPsr         = psrQ;
    entryPsr[DW-1]   = 1'b0;
    if (isIrqQ) entryPsr[PRI_LSB +: PRI_W] = priQ;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      StIdle: begin
        if (exc_req || irqHit) stateNext = StPushPsr;
        else if (rti_req)      stateNext = StPopPc;
      end
      StPushPsr: if (mem_ready) stateNext = StPushPc;
      StPushPc:  if (mem_ready) stateNext = StFetch;
      StFetch:   if (mem_ready) stateNext = StLoad;
      StLoad:    stateNext = StIdle;
      StPopPc:   if (mem_ready) stateNext = StPopPsr;
      StPopPsr:  if (mem_ready) stateNext = StRLoad;
      StRLoad:   stateNext = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= StIdle;
      isIrqQ  <= 1'b0;
      chanQ   <= '0;
      priQ    <= '0;
      vecQ    <= '0;
      pcQ     <= '0;
      psrQ    <= '0;
      sspQ    <= '0;
      dataQ   <= '0;
      newPcQ  <= '0;
      newPsrQ <= '0;
      spOutQ  <= '0;
    end else begin
      state <= stateNext;
      unique case (state)
        // Sampling every idle cycle freezes the values at the acceptance edge.
        StIdle: begin
          pcQ    <= cur_pc;
          psrQ   <= cur_psr;
          sspQ   <= ssp;
          chanQ  <= irqSel;
          priQ   <= bestPri;
          isIrqQ <= !exc_req;
          vecQ   <= exc_req ? exc_vec : IRQ_VEC0 + 8'(irqSel);
        end
        StFetch: if (mem_ready) begin
          newPcQ  <= mem_rdata;
          newPsrQ <= entryPsr;
          spOutQ  <= sspQ - DW'(2);
        end
        // Popped PC is parked so new_pc only changes as RLOAD begins.
        StPopPc: if (mem_ready) dataQ <= mem_rdata;
        StPopPsr: if (mem_ready) begin
          newPcQ  <= dataQ;
          newPsrQ <= mem_rdata;
          spOutQ  <= sspQ + DW'(2);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_we    = 1'b0;
    pc_load   = 1'b0;
    psr_load  = 1'b0;
    sp_load   = 1'b0;
    done      = 1'b0;
    irq_ack   = '0;
    unique case (state)
      StIdle: ;
      StPushPsr: begin
        mem_we    = 1'b1;
        mem_addr  = sspQ - DW'(1);
        mem_wdata = psrQ;
      end
      StPushPc: begin
        mem_we    = 1'b1;
        mem_addr  = sspQ - DW'(2);
        mem_wdata = pcQ;
      end
      StFetch: begin
        mem_rd   = 1'b1;
        mem_addr = VEC_BASE + DW'(vecQ);
      end
      StLoad: begin
        pc_load  = 1'b1;
        psr_load = 1'b1;
        sp_load  = 1'b1;
        done     = 1'b1;
        for (int i = 0; i < int'(NCH); i++) begin
          irq_ack[i] = isIrqQ && (chanQ == 3'(i));
        end
      end
      StPopPc: begin
        mem_rd   = 1'b1;
        mem_addr = sspQ;
      end
      StPopPsr: begin
        mem_rd   = 1'b1;
        mem_addr = sspQ + DW'(1);
      end
      StRLoad: begin
        pc_load  = 1'b1;
        psr_load = 1'b1;
        sp_load  = 1'b1;
        done     = 1'b1;
      end
    endcase
  end

  assign busy    = (state != StIdle);
  assign new_pc  = newPcQ;
  assign new_psr = newPsrQ;
  assign sp_out  = spOutQ;

endmodule
